// File: rtl/op_selector.sv
// Select generator for the 8:1 result mux: debounced next/prev buttons plus an
// optional fixed-rate auto scan, all outputs registered for a glitch-free select.

// Accepts a new level only after it has been stable for DEBOUNCE_CYCLES cycles.
module op_selector_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level
);
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (din == level) begin
         cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
         level <= din;
         cnt   <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end
endmodule

module op_selector #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned SCAN_CYCLES     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_next,
   input  logic       btn_prev,
   input  logic       auto_en,
   input  logic       hold,
   output logic [2:0] sel,
   output logic       sel_changed,
   output logic       auto_active
);
   localparam int unsigned TW = $clog2(SCAN_CYCLES);

   typedef enum logic {
      MANUAL = 1'b0,
      AUTO   = 1'b1
   } state_t;

   state_t        state, state_d;
   logic [2:0]    meta, sync;
   logic          db_next, db_prev, db_next_q, db_prev_q;
   logic          ev_next, ev_prev;
   logic [TW-1:0] timer, timer_d;
   logic [2:0]    sel_d;

   // Two-flop synchronizers: {auto_en, btn_prev, btn_next}
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= {auto_en, btn_prev, btn_next};
         sync <= meta;
      end
   end

   op_selector_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (sync[0]),
      .level (db_next)
   );

   op_selector_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (sync[1]),
      .level (db_prev)
   );

   assign ev_next = db_next & ~db_next_q;
   assign ev_prev = db_prev & ~db_prev_q;

   // Mode, scan timer and select next-state logic
   always_comb begin
      state_d = state;
      timer_d = '0;
      sel_d   = sel;

      case (state)
         MANUAL:  if (sync[2])  state_d = AUTO;
         AUTO:    if (!sync[2]) state_d = MANUAL;
         default: state_d = MANUAL;
      endcase

      if (ev_next && !ev_prev) begin
         sel_d = sel + 3'd1;
      end else if (ev_prev && !ev_next) begin
         sel_d = sel - 3'd1;
      end else if (!ev_next && !ev_prev && state == AUTO && state_d == AUTO) begin
         // Button events and mode changes leave the timer at its cleared default
         if (hold) begin
            timer_d = timer;
         end else if (timer == TW'(SCAN_CYCLES - 1)) begin
            sel_d = sel + 3'd1;
         end else begin
            timer_d = timer + TW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= MANUAL;
         timer       <= '0;
         sel         <= '0;
         sel_changed <= 1'b0;
         auto_active <= 1'b0;
         db_next_q   <= 1'b0;
         db_prev_q   <= 1'b0;
      end else begin
         state       <= state_d;
         timer       <= timer_d;
         sel         <= sel_d;
         sel_changed <= (sel_d != sel);
         auto_active <= (state_d == AUTO);
         db_next_q   <= db_next;
         db_prev_q   <= db_prev;
      end
   end
endmodule

// File: tb/tb_op_selector.sv
// Scoreboard bench for op_selector: stimulus queues expected (sel, cycle) pairs,
// a monitor pops one entry on every sel_changed pulse and compares.
module tb_op_selector;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_next, btn_prev, auto_en, hold;
   logic [2:0] sel;
   logic       sel_changed, auto_active;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int n;
   int exp_sel_q[$];
   int exp_cyc_q[$];

   op_selector #(.DEBOUNCE_CYCLES(4), .SCAN_CYCLES(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_next    (btn_next),
      .btn_prev    (btn_prev),
      .auto_en     (auto_en),
      .hold        (hold),
      .sel         (sel),
      .sel_changed (sel_changed),
      .auto_active (auto_active)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int s, input int c);
      exp_sel_q.push_back(s);
      exp_cyc_q.push_back(c);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Raw press held long enough to debounce; select moves 7 edges after the drive point
   task automatic press(input logic nx, input logic pv, input int exp);
      push(exp, cyc + 7);
      btn_next = nx;
      btn_prev = pv;
      repeat (12) @(negedge clk);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   // Monitor: every select change must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n && sel_changed) begin
         if (exp_sel_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_change: sel=%0d at cycle %0d, none expected", sel, cyc);
         end else begin
            int es, ec;
            es = exp_sel_q.pop_front();
            ec = exp_cyc_q.pop_front();
            check("sb_sel", int'(sel), es);
            check("sb_cycle", cyc, ec);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; auto_en = 1'b0; hold = 1'b0;
      #2;
      check("reset_sel", int'(sel), 0);
      check("reset_changed", int'(sel_changed), 0);
      check("reset_auto", int'(auto_active), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 3-cycle glitch must be filtered
      btn_next = 1'b1;
      repeat (3) @(negedge clk);
      btn_next = 1'b0;
      repeat (12) @(negedge clk);
      check("glitch_sel", int'(sel), 0);

      // Held press steps once
      press(1'b1, 1'b0, 1);
      check("held_sel", int'(sel), 1);
      press(1'b0, 1'b1, 0);

      // Wrap forward 1..7,0 then prev at 0 wraps to 7
      for (int i = 1; i <= 8; i++) press(1'b1, 1'b0, i % 8);
      check("wrap_fwd_sel", int'(sel), 0);
      press(1'b0, 1'b1, 7);
      check("wrap_back_sel", int'(sel), 7);
      press(1'b1, 1'b0, 0);

      // Simultaneous next+prev cancels
      btn_next = 1'b1; btn_prev = 1'b1;
      repeat (12) @(negedge clk);
      btn_next = 1'b0; btn_prev = 1'b0;
      repeat (10) @(negedge clk);
      check("cancel_sel", int'(sel), 0);

      // AUTO scan, hold stretch, button at terminal count, then exit
      n = cyc;
      auto_en = 1'b1;
      push(1, n + 11);
      push(2, n + 19);
      push(3, n + 27);
      push(4, n + 40);
      push(5, n + 48);
      push(6, n + 56);
      wait_until(n + 2);
      check("auto_latency_lo", int'(auto_active), 0);
      wait_until(n + 3);
      check("auto_latency_hi", int'(auto_active), 1);
      wait_until(n + 29);
      hold = 1'b1;
      wait_until(n + 34);
      hold = 1'b0;
      wait_until(n + 41);
      btn_next = 1'b1;
      wait_until(n + 51);
      btn_next = 1'b0;
      wait_until(n + 58);
      auto_en = 1'b0;
      wait_until(n + 75);
      check("manual_auto", int'(auto_active), 0);
      check("manual_sel", int'(sel), 6);

      // Asynchronous reset in the middle of AUTO with sel=5
      press(1'b0, 1'b1, 5);
      auto_en = 1'b1;
      repeat (5) @(negedge clk);
      check("pre_reset_sel", int'(sel), 5);
      check("pre_reset_auto", int'(auto_active), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_sel", int'(sel), 0);
      check("async_reset_changed", int'(sel_changed), 0);
      check("async_reset_auto", int'(auto_active), 0);
      auto_en = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("post_reset_sel", int'(sel), 0);
      check("scoreboard_drained", exp_sel_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
